// File: rtl/affine_dec_seq.sv
// Sequential affine-cipher decoder.
// Latches a key (m, a, b), derives a^-1 mod m with an iterative extended-Euclid
// FSM (one quotient/remainder step per clock), then decodes a ciphertext stream
// x = a^-1 * (y - b) mod m through a fixed-latency, full-throughput pipeline.
module affine_dec_seq #(
    parameter int IP_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    input  logic [IP_WIDTH-1:0] cfg_mod,
    input  logic [IP_WIDTH-1:0] cfg_a,
    input  logic [IP_WIDTH-1:0] cfg_b,
    input  logic                in_valid,
    input  logic [IP_WIDTH-1:0] in_data,
    output logic                key_ready,
    output logic                key_err,
    output logic [IP_WIDTH-1:0] key_inv,
    output logic                out_valid,
    output logic [IP_WIDTH-1:0] out_data
);

    localparam int W = IP_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INV,
        ST_FIN,
        ST_READY,
        ST_ERR
    } state_e;

    state_e state_q, state_d;

    // Key registers (a and b are stored already reduced mod m)
    logic [W-1:0] mod_q, a_q, b_q;
    logic [W-1:0] key_inv_q;

    // Extended-Euclid working set; t values are two's complement, W+1 bits
    logic [W-1:0] r0_q, r1_q;
    logic [W:0]   t0_q, t1_q;

    // Data pipeline: S1 holds (y - b) mod m, S2 holds the raw product
    logic           s1_valid_q, s2_valid_q, out_valid_q;
    logic [W-1:0]   s1_d_q;
    logic [2*W-1:0] s2_prod_q;
    logic [W-1:0]   out_data_q;

    // ------------------------------------------------------------------
    // Control decodes
    // ------------------------------------------------------------------
    logic cfg_take;   // a new key is accepted this cycle
    logic sym_take;   // a ciphertext symbol enters S1 this cycle

    assign cfg_take = cfg_valid &&
                      (state_q == ST_IDLE || state_q == ST_READY || state_q == ST_ERR);
    // A key load in the same cycle wins over the symbol
    assign sym_take = in_valid && (state_q == ST_READY) && !cfg_valid;

    // Divisors are forced non-zero so the modulo units never see m = 0;
    // the FSM routes such keys to ERR anyway.
    logic [W-1:0] cfg_div, mod_div, r1_div;
    assign cfg_div = (cfg_mod == '0) ? W'(1) : cfg_mod;
    assign mod_div = (mod_q == '0)   ? W'(1) : mod_q;
    assign r1_div  = (r1_q == '0)    ? W'(1) : r1_q;

    // ------------------------------------------------------------------
    // Euclid step arithmetic
    // ------------------------------------------------------------------
    logic [W-1:0]   quot, rem;
    logic [2*W+1:0] q_ext, t0_ext, t1_ext, t_diff;
    logic [W:0]     t_new;
    logic [W:0]     t_adj;
    logic [W-1:0]   inv_fin;

    assign quot   = r0_q / r1_div;
    assign rem    = r0_q % r1_div;
    assign q_ext  = {{(W+2){1'b0}}, quot};
    assign t0_ext = {{(W+1){t0_q[W]}}, t0_q};
    assign t1_ext = {{(W+1){t1_q[W]}}, t1_q};
    // Wide modular arithmetic; the true result always fits in W+1 signed bits
    assign t_diff = t0_ext - q_ext * t1_ext;
    assign t_new  = t_diff[W:0];
    // Fold a negative Bezout coefficient back into [0, m-1]
    assign t_adj   = t0_q[W] ? (t0_q + {1'b0, mod_q}) : t0_q;
    assign inv_fin = t_adj[W-1:0];

    // ------------------------------------------------------------------
    // Data-path arithmetic
    // ------------------------------------------------------------------
    logic [W-1:0]   y_red, sym_d;
    logic [2*W-1:0] prod_d, out_rem;

    assign y_red   = in_data % mod_div;
    assign sym_d   = (y_red >= b_q) ? (y_red - b_q) : (y_red + (mod_q - b_q));
    assign prod_d  = key_inv_q * s1_d_q;
    assign out_rem = s2_prod_q % {{W{1'b0}}, mod_div};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first keeps every path assigned, so no latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_READY, ST_ERR: if (cfg_valid) state_d = ST_LOAD;
            ST_LOAD:  state_d = (mod_q < W'(2) || a_q == '0) ? ST_ERR : ST_INV;
            ST_INV:   if (rem == '0) state_d = ST_FIN;
            ST_FIN:   state_d = (r0_q == W'(1)) ? ST_READY : ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        key_ready = (state_q == ST_READY);
        key_err   = (state_q == ST_ERR);
    end

    assign key_inv   = key_inv_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Key capture, Euclid iteration and inverse commit
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these registers are reset too because key_inv and out_data
        // are visible outputs that must read 0 after reset.
        if (!rst_n) begin
            mod_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            key_inv_q <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
        end else begin
            if (cfg_take) begin
                mod_q     <= cfg_mod;
                a_q       <= cfg_a % cfg_div;
                b_q       <= cfg_b % cfg_div;
                key_inv_q <= '0;
            end
            case (state_q)
                ST_LOAD: begin
                    r0_q <= mod_q;
                    r1_q <= a_q;
                    t0_q <= '0;
                    t1_q <= (W+1)'(1);
                end
                ST_INV: begin
                    r0_q <= r1_q;
                    r1_q <= rem;
                    t0_q <= t1_q;
                    t1_q <= t_new;
                end
                ST_FIN: begin
                    if (r0_q == W'(1)) key_inv_q <= inv_fin;
                end
                default: ;
            endcase
        end
    end

    // Pipeline valids; a key load flushes every symbol in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (cfg_take) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= sym_take;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
        end
    end

    // Pipeline data; stages only load on a valid so out_data holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_d_q     <= '0;
            s2_prod_q  <= '0;
            out_data_q <= '0;
        end else begin
            if (sym_take)                s1_d_q     <= sym_d;
            if (s1_valid_q)              s2_prod_q  <= prod_d;
            if (s2_valid_q && !cfg_take) out_data_q <= out_rem[W-1:0];
        end
    end

endmodule

// File: tb/tb_affine_dec_seq.sv
// Self-checking bench for affine_dec_seq: directed key loads and symbol
// streams, with a timestamped scoreboard of expected plaintext.
module tb_affine_dec_seq;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_mod = '0, cfg_a = '0, cfg_b = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         key_ready, key_err, out_valid;
    logic [W-1:0] key_inv, out_data;

    affine_dec_seq #(.IP_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_mod   (cfg_mod),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .key_ready (key_ready),
        .key_err   (key_err),
        .key_inv   (key_inv),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int due;
    } exp_t;

    exp_t sb[$];

    // Current key as seen by the reference model
    int cur_m   = 0;
    int cur_b   = 0;
    int cur_inv = -1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Brute-force modular inverse; -1 when none exists or m < 2
    function automatic int model_inv(input int m, input int a);
        if (m < 2) return -1;
        for (int i = 1; i < m; i++)
            if (((a % m) * i) % m == 1) return i;
        return -1;
    endfunction

    function automatic int model_out(input int y);
        int d;
        d = ((y % cur_m) - (cur_b % cur_m) + cur_m) % cur_m;
        return (cur_inv * d) % cur_m;
    endfunction

    // Pulse cfg_valid (optionally with a colliding symbol), then poll for the verdict
    task automatic load_key(input int m, input int a, input int b,
                            input bit with_sym, input int y);
        bit done;
        cfg_mod   = m[W-1:0];
        cfg_a     = a[W-1:0];
        cfg_b     = b[W-1:0];
        cfg_valid = 1'b1;
        if (with_sym) begin
            in_valid = 1'b1;
            in_data  = y[W-1:0];
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        cur_m   = m;
        cur_b   = b;
        cur_inv = model_inv(m, a);
        done = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (key_ready || key_err) begin
                done = 1'b1;
                break;
            end
        end
        check("key_done", 16'(done), 16'd1);
        check("key_ready", 16'(key_ready), 16'(cur_inv >= 0));
        check("key_err", 16'(key_err), 16'(cur_inv < 0));
        check("key_inv", 16'(key_inv), 16'((cur_inv >= 0) ? cur_inv : 0));
    endtask

    // Drive one symbol for one edge; expected plaintext is due two edges later
    task automatic sym(input int y, input bit expect_out);
        in_valid = 1'b1;
        in_data  = y[W-1:0];
        if (expect_out) sb.push_back('{model_out(y), cyc + 3});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain", 16'(sb.size()), 16'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key_ready"}, 16'(key_ready), 16'd0);
        check({tag, "_key_err"},   16'(key_err),   16'd0);
        check({tag, "_key_inv"},   16'(key_inv),   16'd0);
        check({tag, "_out_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_out_data"},  16'(out_data),  16'd0);
    endtask

    // Output monitor: every out_valid must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 16'(out_valid), 16'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 16'(out_data), 16'(e.data));
                check("out_cycle", 16'(cyc), 16'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // m=26, a=5, b=8: inverse 21, back-to-back stream
        load_key(26, 5, 8, 1'b0, 0);
        sym(17, 1'b1);
        sym(8, 1'b1);
        sym(3, 1'b1);
        drain();
        check("out_hold", 16'(out_data), 16'(model_out(3)));

        // Reset asserted while the inverse is being iterated
        cfg_mod   = 6'd26;
        cfg_a     = 6'd5;
        cfg_b     = 6'd8;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_inv_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_key_ready", 16'(key_ready), 16'd0);
        check("post_reset_key_err", 16'(key_err), 16'd0);

        // Non-invertible key: symbols must be ignored
        load_key(26, 13, 0, 1'b0, 0);
        sym(5, 1'b0);
        repeat (5) @(negedge clk);
        check("err_hold", 16'(key_err), 16'd1);

        // Key and symbol reduction mod m
        load_key(7, 10, 9, 1'b0, 0);
        sym(12, 1'b1);
        drain();

        // Modulus below 2
        load_key(1, 3, 0, 1'b0, 0);

        // Largest modulus
        load_key(63, 62, 0, 1'b0, 0);
        sym(62, 1'b1);
        sym(0, 1'b1);
        sym(63, 1'b1);
        drain();

        // Two symbols in flight, then a key load colliding with a third symbol
        sym(5, 1'b0);
        sym(7, 1'b0);
        load_key(2, 1, 1, 1'b1, 9);
        sym(0, 1'b1);
        drain();

        repeat (4) @(negedge clk);
        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
